// File: rtl/nbbpu_mailbox_pkg.sv
// nbbpu_mailbox_pkg: register offsets, verdict state encoding and the pass code shared by the mailbox.
package nbbpu_mailbox_pkg;
    localparam logic [3:0]  OFS_RESULT  = 4'h0;
    localparam logic [3:0]  OFS_TX_DATA = 4'h2;
    localparam logic [3:0]  OFS_CYC_LO  = 4'h4;
    localparam logic [3:0]  OFS_CYC_HI  = 4'h6;
    localparam logic [3:0]  OFS_WDOG    = 4'h8;
    localparam logic [15:0] PASS_CODE   = 16'h0001;

    typedef enum logic [1:0] {
        ST_RUNNING = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    function automatic logic [15:0] result_word(input state_t s);
        return {12'b0, s == ST_TIMEOUT, s == ST_FAIL || s == ST_TIMEOUT, s == ST_PASS, s != ST_RUNNING};
    endfunction
endpackage

// File: rtl/mailbox_fifo.sv
// mailbox_fifo: power-of-two circular TX byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module mailbox_fifo
    import nbbpu_mailbox_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop,
    output logic [AW:0]      o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rp];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end
endmodule

// File: rtl/nbbpu_mailbox.sv
// nbbpu_mailbox: result mailbox, TX FIFO and cycle counter on the NBBPU data bus.
// Optional watchdog enabled by defining NBBPU_MAILBOX_WDOG_EN.
module nbbpu_mailbox
    import nbbpu_mailbox_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFFF0,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] WDOG_DEFAULT = 16'h0FFF,
    localparam int         CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_select,
    input  logic        i_read_enable,
    input  logic        i_write_enable,
    input  logic [15:0] i_address,
    input  logic [15:0] i_write_data,
    output logic [15:0] o_read_data,
    output logic [7:0]  o_char_data,
    output logic        o_char_valid,
    input  logic        i_char_ready,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_fail,
    output logic        o_timeout
);
    state_t        r_state, w_state_nxt;
    logic [15:0]   w_rel, w_rd_val, w_tx_status, w_wdog_rd;
    logic [3:0]    w_ofs;
    logic          w_rd, w_wr, w_wr_result, w_wr_tx, w_rd_tx, w_rd_lo, w_expire;
    logic          w_full, w_empty, w_drop;
    logic [CW-1:0] w_count;
    logic [4:0]    w_count5;
    logic [15:0]   r_read_data, r_hi_shadow;
    logic [31:0]   r_cycle;
    logic          r_overflow;

    // Window check by subtraction so BASE_ADDR need not be 16-aligned.
    assign w_rel       = i_address - BASE_ADDR;
    assign w_ofs       = w_rel[3:0];
    assign w_rd        = i_select & i_read_enable & (w_rel[15:4] == 12'h0);
    assign w_wr        = i_select & i_write_enable & (w_rel[15:4] == 12'h0);
    assign w_wr_result = w_wr & (w_ofs == OFS_RESULT);
    assign w_wr_tx     = w_wr & (w_ofs == OFS_TX_DATA);
    assign w_rd_tx     = w_rd & (w_ofs == OFS_TX_DATA);
    assign w_rd_lo     = w_rd & (w_ofs == OFS_CYC_LO);

    mailbox_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_wr_tx),
        .i_data  (i_write_data[7:0]),
        .i_pop   (i_char_ready),
        .o_data  (o_char_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    assign o_char_valid = ~w_empty;
    assign w_count5     = 5'(w_count);
    assign w_tx_status  = {8'b0, r_overflow, w_full, w_empty, w_count5};

    assign w_rd_val = (w_ofs == OFS_RESULT)  ? result_word(r_state) :
                      (w_ofs == OFS_TX_DATA) ? w_tx_status :
                      (w_ofs == OFS_CYC_LO)  ? r_cycle[15:0] :
                      (w_ofs == OFS_CYC_HI)  ? r_hi_shadow :
                      (w_ofs == OFS_WDOG)    ? w_wdog_rd : 16'h0;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_read_data <= '0;
            r_hi_shadow <= '0;
            r_cycle     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_read_data <= w_rd ? w_rd_val : 16'h0;
            r_cycle     <= r_cycle + 1'b1;
            if (w_rd_lo) r_hi_shadow <= r_cycle[31:16];
            // A drop in the same cycle as a status read stays visible to the next read.
            if (w_drop) r_overflow <= 1'b1;
            else if (w_rd_tx) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_RUNNING;
        else r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUNNING)
            w_state_nxt = w_wr_result ? ((i_write_data == PASS_CODE) ? ST_PASS : ST_FAIL) :
                          w_expire    ? ST_TIMEOUT : ST_RUNNING;
    end

`ifdef NBBPU_MAILBOX_WDOG_EN
    logic [15:0] r_wdog_cnt, r_wdog_limit;
    logic        w_wr_wdog;

    assign w_wr_wdog = w_wr & (w_ofs == OFS_WDOG);
    assign w_expire  = (r_state == ST_RUNNING) & (r_wdog_limit != 16'h0) & (r_wdog_cnt == r_wdog_limit);
    assign w_wdog_rd = r_wdog_limit;
    assign o_timeout = r_state == ST_TIMEOUT;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wdog_cnt   <= '0;
            r_wdog_limit <= WDOG_DEFAULT;
        end else if (w_wr_wdog) begin
            r_wdog_cnt   <= '0;
            r_wdog_limit <= i_write_data;
        end else if (r_state == ST_RUNNING) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end
`else
    assign w_expire  = 1'b0;
    assign w_wdog_rd = 16'h0;
    assign o_timeout = 1'b0;
`endif

    assign o_read_data = r_read_data;
    assign o_done      = r_state != ST_RUNNING;
    assign o_pass      = r_state == ST_PASS;
    assign o_fail      = (r_state == ST_FAIL) | (r_state == ST_TIMEOUT);
endmodule

// File: tb/tb_nbbpu_mailbox.sv
// tb_nbbpu_mailbox: directed self-checking bench for the result mailbox, TX FIFO and cycle counter.
module tb_nbbpu_mailbox;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0, re = 1'b0, we = 1'b0, ready = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic [15:0] rdata;
    logic [7:0]  cdata;
    logic        cvalid, done, pass, fail, tmo;
    logic [31:0] ncyc;
    logic [15:0] v, lo_exp;
    int          n_run = 0, n_fail = 0;

    nbbpu_mailbox dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_select       (sel),
        .i_read_enable  (re),
        .i_write_enable (we),
        .i_address      (addr),
        .i_write_data   (wdata),
        .o_read_data    (rdata),
        .o_char_data    (cdata),
        .o_char_valid   (cvalid),
        .i_char_ready   (ready),
        .o_done         (done),
        .o_pass         (pass),
        .o_fail         (fail),
        .o_timeout      (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= '0;
        else ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sel = 1'b0; re = 1'b0; we = 1'b0; ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        sel = 1'b1; re = 1'b1; addr = a;
        @(negedge clk);
        sel = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    initial begin
        do_reset();
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_cvalid", cvalid, 0);
        chk("rst_rdata", rdata, 0);
        rd(16'hFFF2, v); chk("rst_tx_status", v, 16'h0020);
        rd(16'hFFF1, v); chk("undef_ofs_read", v, 16'h0000);
        sel = 1'b0; we = 1'b1; addr = 16'hFFF0; wdata = 16'h0002;
        @(negedge clk);
        we = 1'b0;
        chk("unselected_write", done, 0);

        // 1: pass verdict, later writes ignored
        wr(16'hFFF0, 16'h0001);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_fail", fail, 0);
        wr(16'hFFF0, 16'h0000);
        chk("t1_pass_sticky", pass, 1);
        chk("t1_fail_sticky", fail, 0);
        rd(16'hFFF0, v); chk("t1_result_rd", v, 16'h0003);
        @(negedge clk);
        chk("t1_rdata_clears", rdata, 16'h0000);

        // 2: fail verdict
        do_reset();
        wr(16'hFFF0, 16'h0002);
        chk("t2_fail", fail, 1);
        chk("t2_pass", pass, 0);
        rd(16'hFFF0, v); chk("t2_result_rd", v, 16'h0005);

        // 3: FIFO overflow and in-order drain
        do_reset();
        for (int i = 0; i < 9; i++) wr(16'hFFF2, 16'h0041 + 16'(i));
        rd(16'hFFF2, v); chk("t3_status_ovf", v, 16'h00C8);
        rd(16'hFFF2, v); chk("t3_status_clr", v, 16'h0048);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_valid%0d", i), cvalid, 1);
            chk($sformatf("t3_char%0d", i), cdata, 8'h41 + 8'(i));
            @(negedge clk);
        end
        chk("t3_drained", cvalid, 0);
        ready = 1'b0;

        // 4: cycle counter and coherent LO/HI read across the 16-bit wrap
        do_reset();
        repeat (100) @(negedge clk);
        rd(16'hFFF4, v); chk("t4_lo100", v, 16'h0064);
        rd(16'hFFF6, v); chk("t4_hi0", v, 16'h0000);
        for (int i = 0; i < 70000 && ncyc != 32'h0000FFFF; i++) @(negedge clk);
        chk("t4_reach_wrap", ncyc, 32'h0000FFFF);
        rd(16'hFFF4, v); chk("t4_lo_ffff", v, 16'hFFFF);
        rd(16'hFFF6, v); chk("t4_hi_coherent", v, 16'h0000);
        lo_exp = ncyc[15:0];
        rd(16'hFFF4, v); chk("t4_lo_after", v, lo_exp);
        rd(16'hFFF6, v); chk("t4_hi_after", v, 16'h0001);

        // 5: watchdog
`ifdef NBBPU_MAILBOX_WDOG_EN
        do_reset();
        wr(16'hFFF8, 16'h0010);
        repeat (16) @(negedge clk);
        chk("t5_not_yet", tmo, 0);
        @(negedge clk);
        chk("t5_timeout", tmo, 1);
        chk("t5_fail", fail, 1);
        chk("t5_done", done, 1);
        rd(16'hFFF8, v); chk("t5_limit_rd", v, 16'h0010);
        do_reset();
        wr(16'hFFF8, 16'h0010);
        repeat (16) @(negedge clk);
        wr(16'hFFF0, 16'h0001);
        chk("t5_result_wins_pass", pass, 1);
        chk("t5_result_wins_tmo", tmo, 0);
`else
        do_reset();
        wr(16'hFFF8, 16'h0010);
        rd(16'hFFF8, v); chk("t5_wdog_absent", v, 16'h0000);
        chk("t5_timeout_tied", tmo, 0);
`endif

        // 6: asynchronous reset mid-operation
        do_reset();
        wr(16'hFFF0, 16'h0002);
        for (int i = 0; i < 3; i++) wr(16'hFFF2, 16'h0030 + 16'(i));
        sel = 1'b1; re = 1'b1; addr = 16'hFFF0;
        @(negedge clk);
        chk("t6_pre_rdata", rdata, 16'h0005);
        chk("t6_pre_cvalid", cvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_cvalid", cvalid, 0);
        chk("t6_done", done, 0);
        chk("t6_fail", fail, 0);
        chk("t6_rdata", rdata, 16'h0000);
        sel = 1'b0; re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(16'hFFF2, v); chk("t6_fifo_empty", v, 16'h0020);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
